trace_src_arbiter: RTL and testbench

- Round-robin arbiter that shares one trace FIFO write port between `num_src_p` trace sample sources.
- Sources have no ready signal. Samples that are not granted are dropped and counted per source.
- When a source with a nonzero drop count is next granted, the block emits a drop-count packet instead of a sample.
- The block sits between the per-unit sample taps and the trace FIFO. It replaces a single-source backpressure stage when several units share the trace path.

---
 rtl/trace_dbg_pkg.sv | 25 ++
 rtl/trace_rr_arb.sv | 64 ++++++
 rtl/trace_src_arbiter.sv | 133 +++++++++++++
 tb/tb_trace_src_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/trace_dbg_pkg.sv
// trace_dbg_pkg: shared definitions for the trace source arbiter.
//   - Packet field bit positions for the default geometry
//     (16-bit payload, 2-bit source id).
//   - Packet type constants PKT_SAMPLE / PKT_DROP.
//   - trace_pkt_s: packed packet layout {is_drop, src_id, payload}.
// Build option: TRACE_ARB_FIXED_PRIO_EN (see trace_rr_arb).
package trace_dbg_pkg;

  localparam int TRACE_SAMPLE_W  = 16;
  localparam int TRACE_ID_W      = 2;

  localparam int PKT_PAYLOAD_LSB = 0;
  localparam int PKT_ID_LSB      = TRACE_SAMPLE_W;
  localparam int PKT_DROP_BIT    = TRACE_SAMPLE_W + TRACE_ID_W;

  localparam logic PKT_SAMPLE = 1'b0;
  localparam logic PKT_DROP   = 1'b1;

  typedef struct packed {
    logic                      is_drop;
    logic [TRACE_ID_W-1:0]     src_id;
    logic [TRACE_SAMPLE_W-1:0] payload;
  } trace_pkt_s;

endpackage

// File: rtl/trace_rr_arb.sv
// trace_rr_arb: combinational num_src_p-way selector.
// Ports:
//   req        in  num_src_p   request vector
//   last_grant in  id_width_p  previously granted source (round-robin build only)
//   grant_oh   out num_src_p   one-hot grant
//   grant_id   out id_width_p  encoded grant
//   grant_any  out 1           at least one request granted
// Macro TRACE_ARB_FIXED_PRIO_EN: when defined, lowest index wins and the
// last_grant port does not exist; otherwise round-robin starting after
// last_grant.
module trace_rr_arb
  import trace_dbg_pkg::*;
#(
  parameter int num_src_p  = 4,
  parameter int id_width_p = $clog2(num_src_p)
) (
  input  logic [num_src_p-1:0]  req,
`ifndef TRACE_ARB_FIXED_PRIO_EN
  input  logic [id_width_p-1:0] last_grant,
`endif
  output logic [num_src_p-1:0]  grant_oh,
  output logic [id_width_p-1:0] grant_id,
  output logic                  grant_any
);

`ifdef TRACE_ARB_FIXED_PRIO_EN

  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < num_src_p; i++) begin
      if (!grant_any && req[i]) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_id    = id_width_p'(i);
      end
    end
  end

`else

  // Walk last_grant+1 .. last_grant+num_src_p; the wrap is a single
  // conditional subtract since the sum never reaches 2*num_src_p.
  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= num_src_p; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (!grant_any && req[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = id_width_p'(idx);
      end
    end
  end

`endif

endmodule

// File: rtl/trace_src_arbiter.sv
// trace_src_arbiter: shares one trace FIFO write port between num_src_p
// sample sources that cannot be back-pressured. Ungranted samples are
// counted per source; the next grant of a source with a nonzero count
// emits a drop packet {1, id, count} instead of a sample {0, id, data}.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   src_en        per-source enable (disabled: never granted, count cleared)
//   sample_data   packed samples, source i at [i*sample_width_p +: sample_width_p]
//   sample_valid  per-source sample strobe
//   fifo_data     registered packet {is_drop, src_id, payload}
//   fifo_valid    packet valid
//   fifo_ready    FIFO accepts packet
// Macro TRACE_ARB_FIXED_PRIO_EN: fixed priority (lowest index) instead of
// round-robin; last_grant register is then absent.
module trace_src_arbiter
  import trace_dbg_pkg::*;
#(
  parameter int num_src_p       = 4,
  parameter int sample_width_p  = 16,
  parameter int counter_width_p = 8,
  parameter int id_width_p      = $clog2(num_src_p)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [num_src_p-1:0]                src_en,
  input  logic [num_src_p*sample_width_p-1:0] sample_data,
  input  logic [num_src_p-1:0]                sample_valid,
  output logic [id_width_p+sample_width_p:0]  fifo_data,
  output logic                                fifo_valid,
  input  logic                                fifo_ready
);

  localparam int                   pkt_w   = 1 + id_width_p + sample_width_p;
  localparam logic [counter_width_p-1:0] ctr_max = '1;

  logic [num_src_p-1:0][counter_width_p-1:0] ctr, ctr_nxt;
  logic [num_src_p-1:0]       elig, req, grant_oh;
  logic [id_width_p-1:0]      grant_id;
  logic                       grant_any, load;
  logic [sample_width_p-1:0]  g_data;
  logic [counter_width_p-1:0] g_ctr;
  logic [pkt_w-1:0]           pkt;

  // Output register can take a new packet when empty or being drained.
  assign load = !fifo_valid || fifo_ready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < num_src_p; i++)
      elig[i] = src_en[i] && (sample_valid[i] || ctr[i] != '0);
  end

  // Gating requests with load means a stall produces no grant, so every
  // valid sample during a stall falls through to the counting path.
  assign req = load ? elig : '0;

`ifdef TRACE_ARB_FIXED_PRIO_EN
  trace_rr_arb #(
    .num_src_p  (num_src_p),
    .id_width_p (id_width_p)
  ) u_arb (
    .req       (req),
    .grant_oh  (grant_oh),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );
`else
  logic [id_width_p-1:0] last_grant;

  trace_rr_arb #(
    .num_src_p  (num_src_p),
    .id_width_p (id_width_p)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant_oh   (grant_oh),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_grant <= id_width_p'(num_src_p - 1);
    else if (grant_any) last_grant <= grant_id;
  end
`endif

  // One-hot mux of the granted source's data and count.
  always_comb begin
    g_data = '0;
    g_ctr  = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (grant_oh[i]) begin
        g_data = sample_data[i*sample_width_p +: sample_width_p];
        g_ctr  = ctr[i];
      end
    end
  end

  always_comb begin
    if (g_ctr != '0) pkt = {PKT_DROP, grant_id, sample_width_p'(g_ctr)};
    else             pkt = {PKT_SAMPLE, grant_id, g_data};
  end

  // Counter next state. A granted source reporting drops loses any sample
  // presented in the same cycle, so its count restarts at 1.
  always_comb begin
    ctr_nxt = ctr;
    for (int i = 0; i < num_src_p; i++) begin
      if (!src_en[i])
        ctr_nxt[i] = '0;
      else if (grant_oh[i])
        ctr_nxt[i] = (ctr[i] != '0 && sample_valid[i]) ? counter_width_p'(1) : '0;
      else if (sample_valid[i] && ctr[i] != ctr_max)
        ctr_nxt[i] = ctr[i] + counter_width_p'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctr <= '0;
    else     ctr <= ctr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_valid <= 1'b0;
      fifo_data  <= '0;
    end else if (load) begin
      fifo_valid <= grant_any;
      if (grant_any) fifo_data <= pkt;
    end
  end

endmodule

// File: tb/tb_trace_src_arbiter.sv
module tb_trace_src_arbiter;
  localparam int N   = 4;
  localparam int SW  = 16;
  localparam int CW  = 8;
  localparam int IW  = 2;
  localparam int PW  = 1 + IW + SW;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src_en = '0;
  logic [N*SW-1:0] sample_data = '0;
  logic [N-1:0]  sample_valid = '0;
  logic [PW-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_ready = 1'b0;

  trace_src_arbiter #(
    .num_src_p       (N),
    .sample_width_p  (SW),
    .counter_width_p (CW),
    .id_width_p      (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_en       (src_en),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_ready   (fifo_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: drop counts, last winner and whether the output slot
  // holds a packet. Expected packets go to exp_q in delivery order.
  logic [PW-1:0] exp_q[$];
  int m_ctr[N];
  int m_last;
  bit m_valid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ctr[i] = 0;
    m_last  = N - 1;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [N*SW-1:0] rnd_data();
    logic [N*SW-1:0] d;
    for (int i = 0; i < N; i++) d[i*SW +: SW] = SW'($urandom);
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, step past the edge.
  task automatic drive(input logic [N-1:0] en, input logic [N-1:0] vld,
                       input logic rdy, input logic [N*SW-1:0] d);
    int g;
    bit ld;
    src_en = en; sample_valid = vld; fifo_ready = rdy; sample_data = d;
    ld = !m_valid || rdy;
    g  = -1;
    if (ld) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && en[j] && (vld[j] || m_ctr[j] != 0)) g = j;
      end
    end
    if (g >= 0) begin
      if (m_ctr[g] != 0) exp_q.push_back({1'b1, IW'(g), SW'(m_ctr[g])});
      else               exp_q.push_back({1'b0, IW'(g), d[g*SW +: SW]});
      m_last  = g;
      m_valid = 1'b1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!en[i])                        m_ctr[i] = 0;
      else if (i == g)                   m_ctr[i] = (m_ctr[i] != 0 && vld[i]) ? 1 : 0;
      else if (vld[i] && m_ctr[i] < MAX) m_ctr[i]++;
    end
    @(posedge clk); #1;
  endtask

  // Monitor: each accepted packet is compared with the next expected one.
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && fifo_valid && fifo_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pkt_unexpected: got=%h want=none", fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            bad++;
            $display("FAIL pkt: got=%h want=%h", fifo_data, e);
          end
        end
      end
    end
  end

  initial begin
    logic [N*SW-1:0] d;
    logic [PW-1:0]   held;
    model_reset();
    @(posedge clk); #1;
    chk("rst_valid", 32'(fifo_valid), 0);
    chk("rst_data",  32'(fifo_data), 0);
    rst = 1'b0;

    // single source 2
    d = rnd_data(); d[2*SW +: SW] = 16'h1234;
    drive(4'hF, 4'b0100, 1'b1, d);
    chk("single_valid", 32'(fifo_valid), 1);
    chk("single_data",  32'(fifo_data), 32'h21234);
    drive(4'hF, 4'b0000, 1'b1, rnd_data());
    chk("single_idle", 32'(fifo_valid), 0);

    // all valid, ready high
    repeat (12) drive(4'hF, 4'hF, 1'b1, rnd_data());
    repeat (6)  drive(4'hF, 4'h0, 1'b1, rnd_data());

    // stall with src 0 valid
    drive(4'hF, 4'b0001, 1'b1, rnd_data());
    held = fifo_data;
    repeat (5) drive(4'hF, 4'b0001, 1'b0, rnd_data());
    chk("stall_frozen", 32'(fifo_data), 32'(held));
    chk("stall_valid",  32'(fifo_valid), 1);
    drive(4'hF, 4'b0001, 1'b1, rnd_data());
    chk("stall_drop", 32'(fifo_data), 32'h40005);
    repeat (6) drive(4'hF, 4'h0, 1'b1, rnd_data());

    // saturation on src 1
    drive(4'hF, 4'b0010, 1'b1, rnd_data());
    repeat (300) drive(4'hF, 4'b0010, 1'b0, rnd_data());
    drive(4'hF, 4'b0000, 1'b1, rnd_data());
    chk("sat_drop", 32'(fifo_data), 32'h500FF);
    repeat (6) drive(4'hF, 4'h0, 1'b1, rnd_data());

    // disable src 3 with a pending count
    drive(4'hF, 4'b1000, 1'b1, rnd_data());
    repeat (3) drive(4'hF, 4'b1000, 1'b0, rnd_data());
    drive(4'b0111, 4'b1000, 1'b1, rnd_data());
    chk("dis_novalid", 32'(fifo_valid), 0);
    drive(4'hF, 4'b0000, 1'b1, rnd_data());
    chk("dis_nodrop", 32'(fifo_valid), 0);
    repeat (20) drive(4'b0111, 4'(($urandom)), ($urandom_range(0, 3) != 0), rnd_data());
    repeat (6)  drive(4'hF, 4'h0, 1'b1, rnd_data());

    // random traffic
    repeat (400) begin
      logic [N-1:0] en;
      en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      drive(en, 4'($urandom), ($urandom_range(0, 3) != 0), rnd_data());
    end
    repeat (6) drive(4'hF, 4'h0, 1'b1, rnd_data());

    // reset with a packet pending
    drive(4'hF, 4'hF, 1'b0, rnd_data());
    chk("prerst_valid", 32'(fifo_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(fifo_valid), 0);
    chk("async_rst_data",  32'(fifo_data), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b1, rnd_data());
    chk("post_rst_src0", 32'(fifo_data[SW +: IW]), 0);
    repeat (8) drive(4'hF, 4'hF, 1'b1, rnd_data());
    repeat (6) drive(4'hF, 4'h0, 1'b1, rnd_data());

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
